// File: rtl/sigmoid_stream_ctrl_if.sv
// Valid/ready stream bundle between the MAC output buffer, the sigmoid sequencer and the write-back path.
// The slave modport is the sequencer side; the master modport is the upstream/downstream side.
interface sigmoid_stream_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sigmoid_stream_ctrl.sv
// Sequencer for the iterative bfloat16 sigmoid engine: accept one word, time the engine, present the result.
// Optional macro SIGMOID_SAT_BYPASS_EN answers saturated/special operands directly without starting the engine.
module sigmoid_stream_ctrl #(
  parameter int         ENGINE_LATENCY = 41,
  parameter logic [7:0] SAT_EXP        = 8'h83
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sigmoid_stream_ctrl_if.slave stream,
  output logic [15:0]          eng_x,
  output logic                 eng_en,
  input  logic [15:0]          eng_result,
  output logic                 busy
);

  localparam int               CNT_W    = $clog2(ENGINE_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ENGINE_LATENCY - 1);

  if (ENGINE_LATENCY < 1) begin : g_bad_latency
    $error("sigmoid_stream_ctrl: ENGINE_LATENCY must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    OUT
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      x_q, x_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef SIGMOID_SAT_BYPASS_EN
  logic        bypass;
  logic [15:0] bypass_result;

  // Infinity is tested before the saturation band because it also satisfies exp >= SAT_EXP.
  always_comb begin
    bypass        = 1'b0;
    bypass_result = 16'h0000;
    if (stream.in_data[14:7] == 8'hFF) begin
      bypass = 1'b1;
      if (stream.in_data[6:0] != 7'd0) begin
        bypass_result = 16'h7FC0;
      end else begin
        bypass_result = stream.in_data[15] ? 16'h0000 : 16'h3F80;
      end
    end else if (stream.in_data[14:7] >= SAT_EXP) begin
      bypass        = 1'b1;
      bypass_result = stream.in_data[15] ? 16'h0000 : 16'h3F80;
    end else if (stream.in_data[14:7] == 8'h00) begin
      bypass        = 1'b1;
      bypass_result = 16'h3F00;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (stream.in_valid) begin
          x_d = stream.in_data;
`ifdef SIGMOID_SAT_BYPASS_EN
          if (bypass) begin
            out_data_d  = bypass_result;
            out_valid_d = 1'b1;
            state_d     = OUT;
          end else begin
            state_d = LOAD;
          end
`else
          state_d = LOAD;
`endif
        end
      end
      LOAD: begin
        cnt_d   = CNT_LOAD;
        state_d = RUN;
      end
      RUN: begin
        if (cnt_q == '0) begin
          out_data_d  = eng_result;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      OUT: begin
        if (stream.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= 16'h0000;
      out_data_q  <= 16'h0000;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  // The engine is held in load whenever it has no fresh operand to iterate on.
  assign eng_en           = (state_q == IDLE) || (state_q == LOAD);
  assign eng_x            = x_q;
  assign busy             = (state_q != IDLE);
  assign stream.in_ready  = (state_q == IDLE);
  assign stream.out_valid = out_valid_q;
  assign stream.out_data  = out_data_q;

endmodule

// File: tb/tb_sigmoid_stream_ctrl.sv
// Scoreboard bench for sigmoid_stream_ctrl with a tagged-value engine model.
// Build with SIGMOID_SAT_BYPASS_EN defined to exercise the bypass path.
`timescale 1ns/1ps
module tb_sigmoid_stream_ctrl;
  localparam int L = 41;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] eng_x;
  logic        eng_en;
  logic [15:0] eng_result;
  logic        busy;

  sigmoid_stream_ctrl_if bus ();

  sigmoid_stream_ctrl #(.ENGINE_LATENCY(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stream     (bus),
    .eng_x      (eng_x),
    .eng_en     (eng_en),
    .eng_result (eng_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  function automatic logic [15:0] eng_tag(input logic [15:0] x);
    return x ^ 16'hA5C3;
  endfunction

  // Engine model: result is the operand's tag from the L-th cycle with eng_en low onward, garbage before.
  int          eng_k  = 0;
  logic [15:0] eng_lx = 16'h0000;
  always @(posedge clk) begin
    if (eng_en) begin
      eng_k  <= 0;
      eng_lx <= eng_x;
    end else if (eng_k < 1000) begin
      eng_k <= eng_k + 1;
    end
  end
  assign eng_result = (eng_k >= L - 1) ? eng_tag(eng_lx) : ~eng_tag(eng_lx);

`ifdef SIGMOID_SAT_BYPASS_EN
  function automatic bit is_bypass(input logic [15:0] x);
    return (x[14:7] == 8'hFF) || (x[14:7] >= 8'h83) || (x[14:7] == 8'h00);
  endfunction

  function automatic logic [15:0] bypass_value(input logic [15:0] x);
    if (x[14:7] == 8'hFF && x[6:0] != 7'd0) return 16'h7FC0;
    if (x[14:7] == 8'hFF || x[14:7] >= 8'h83) return x[15] ? 16'h0000 : 16'h3F80;
    return 16'h3F00;
  endfunction
`endif

  function automatic logic [15:0] ref_result(input logic [15:0] x);
`ifdef SIGMOID_SAT_BYPASS_EN
    if (is_bypass(x)) return bypass_value(x);
`endif
    return eng_tag(x);
  endfunction

  function automatic int ref_latency(input logic [15:0] x);
`ifdef SIGMOID_SAT_BYPASS_EN
    if (is_bypass(x)) return 1;
`endif
    return L + 2;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level reference: one word in flight, result due a fixed latency after acceptance.
  bit          m_pending = 1'b0;
  bit          m_valid   = 1'b0;
  bit          m_bypass  = 1'b0;
  bit          acc_now   = 1'b0;
  int          m_due     = 0;
  int          m_acc_cyc = 0;
  logic [15:0] m_x       = 16'h0000;
  logic [15:0] m_out     = 16'h0000;
  logic [15:0] m_next    = 16'h0000;
  logic [15:0] sb[$];

  always @(posedge clk) begin
    acc_now = 1'b0;
    if (!rst_n) begin
      m_pending = 1'b0;
      m_valid   = 1'b0;
      m_x       = 16'h0000;
      m_out     = 16'h0000;
      sb.delete();
    end else begin
      if (!m_valid && !m_pending && bus.in_valid) begin
        m_x       = bus.in_data;
        m_next    = ref_result(bus.in_data);
        m_due     = cyc + ref_latency(bus.in_data);
        m_bypass  = (ref_latency(bus.in_data) == 1);
        m_acc_cyc = cyc;
        m_pending = 1'b1;
        acc_now   = 1'b1;
        sb.push_back(m_next);
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
      if (m_pending && cyc + 1 == m_due) begin
        m_pending = 1'b0;
        m_valid   = 1'b1;
        m_out     = m_next;
      end
    end
    cyc++;
  end

  bit          chk_en  = 1'b0;
  bit          prev_ov = 1'b0;
  logic [15:0] sb_item;

  always @(negedge clk) begin
    if (chk_en) begin
      check_output("in_ready", 32'(bus.in_ready), 32'(!(m_pending || m_valid)));
      check_output("busy", 32'(busy), 32'(m_pending || m_valid));
      check_output("out_valid", 32'(bus.out_valid), 32'(m_valid));
      check_output("out_data", 32'(bus.out_data), 32'(m_out));
      check_output("eng_x", 32'(eng_x), 32'(m_x));
      check_output("eng_en", 32'(eng_en),
                   32'(!((m_pending || m_valid) && !m_bypass && cyc >= m_acc_cyc + 2)));
      if (bus.out_valid === 1'b1 && !prev_ov) begin
        check_output("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          sb_item = sb.pop_front();
          check_output("sb_result", 32'(bus.out_data), 32'(sb_item));
        end
      end
      prev_ov = (bus.out_valid === 1'b1);
    end
  end

  bit rand_ready = 1'b0;
  bit rnd_ready  = 1'b1;
  bit ready_val  = 1'b1;
  assign bus.out_ready = rand_ready ? rnd_ready : ready_val;
  always @(posedge clk) begin
    #2;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic [15:0] data, output int acc_cyc);
    bit got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    for (int i = 0; i < 400 && !got; i++) begin
      tick(1);
      got = acc_now;
    end
    check_output("accept_seen", 32'(got), 32'd1);
    acc_cyc = m_acc_cyc;
  endtask

  task automatic wait_out(input int acc_cyc, input int exp_lat, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (bus.out_valid === 1'b1) seen = 1'b1;
      else tick(1);
    end
    check_output("out_seen", 32'(seen), 32'd1);
    if (seen) check_output("latency", 32'(cyc - acc_cyc), 32'(exp_lat));
  endtask

  task automatic wait_idle(input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      if (!m_pending && !m_valid) done = 1'b1;
      else tick(1);
    end
    check_output("drain", 32'(done), 32'd1);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 7))
      0: v[14:7] = 8'hFF;
      1: v[14:7] = 8'h00;
      2: v[14:7] = 8'h83 + 8'($urandom_range(0, 16));
      3: v[14:7] = 8'h82;
      default: ;
    endcase
    return v;
  endfunction

  logic [15:0] dir_words[4];
  logic [15:0] dir_exp[4];
  int          acc;
  int          prev_acc;
  int          prev_lat;
  bit          seen;
  logic [15:0] w;

  initial begin
    dir_words = '{16'h4180, 16'hC200, 16'h0000, 16'h7FC1};
`ifdef SIGMOID_SAT_BYPASS_EN
    dir_exp = '{16'h3F80, 16'h0000, 16'h3F00, 16'h7FC0};
`else
    foreach (dir_words[i]) dir_exp[i] = eng_tag(dir_words[i]);
`endif
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0000;
    rst_n        = 1'b0;
    tick(2);
    chk_en = 1'b1;
    check_output("reset_out_data", 32'(bus.out_data), 32'h0);
    check_output("reset_eng_en", 32'(eng_en), 32'd1);
    check_output("reset_eng_x", 32'(eng_x), 32'h0);
    rst_n = 1'b1;

    apply_stimulus(16'h3F80, acc);
    bus.in_valid = 1'b0;
    wait_out(acc, L + 2, seen);
    if (seen) check_output("first_value", 32'(bus.out_data), 32'(eng_tag(16'h3F80)));
    wait_idle(100);

    ready_val = 1'b0;
    w = 16'h3E9A;
    apply_stimulus(w, acc);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h3C00;
    wait_out(acc, L + 2, seen);
    tick(10);
    check_output("stall_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("stall_data", 32'(bus.out_data), 32'(eng_tag(w)));
    ready_val = 1'b1;
    tick(1);
    check_output("stall_release", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
    wait_idle(100);

    prev_acc = -1;
    prev_lat = 0;
    for (int i = 0; i < 3; i++) begin
      w = rand_word();
      apply_stimulus(w, acc);
      if (prev_acc >= 0) check_output("accept_gap", 32'(acc - prev_acc), 32'(prev_lat + 1));
      prev_acc = acc;
      prev_lat = ref_latency(w);
    end
    bus.in_valid = 1'b0;
    wait_idle(100);

    apply_stimulus(16'h3F80, acc);
    bus.in_valid = 1'b0;
    tick(20);
    rst_n = 1'b0;
    tick(1);
    check_output("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("midrst_eng_en", 32'(eng_en), 32'd1);
    check_output("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    tick(L + 10);

    foreach (dir_words[i]) begin
      apply_stimulus(dir_words[i], acc);
      bus.in_valid = 1'b0;
      wait_out(acc, ref_latency(dir_words[i]), seen);
      if (seen) check_output("directed_value", 32'(bus.out_data), 32'(dir_exp[i]));
      wait_idle(100);
    end

    rand_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      bus.in_valid = 1'b0;
      tick($urandom_range(0, 3));
      apply_stimulus(rand_word(), acc);
    end
    bus.in_valid = 1'b0;
    rand_ready   = 1'b0;
    ready_val    = 1'b1;
    wait_idle(200);
    tick(2);
    check_output("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
